// File: rtl/event_sync_queue.sv
// event_sync_queue: per-channel event synchroniser with a saturating
// pending-event counter. Each channel brings a foreign-domain event signal
// through a flop chain, detects toggles or rising edges, queues the events
// and replays them as single-cycle pulses with a minimum spacing and a
// per-channel hold. Only the post-reset warm-up window is shared.
module event_sync_queue #(
  parameter int CH          = 4,
  parameter int CNT_W       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int GAP         = 1,
  parameter bit TOGGLE      = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       ev_in,
  input  logic [CH-1:0]       hold,
  input  logic [CH-1:0]       ovf_clr,
  output logic [CH-1:0]       ev_out,
  output logic [CH-1:0]       full,
  output logic [CH-1:0]       ovf,
  output logic [CH*CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX      = '1;
  localparam int               WARM_LEN = SYNC_STAGES + 1;
  localparam int               WARM_W   = $clog2(WARM_LEN + 1);
  localparam logic [WARM_W-1:0] WARM_END = WARM_W'(WARM_LEN);

  logic [WARM_W-1:0] r_warm;
  logic              w_warm_done;

  // Until the chain has been refilled with real samples, the levels present
  // at reset would look like events; detections are ignored in that window.
  assign w_warm_done = (r_warm == WARM_END);

  // Shared warm-up counter: counts edges after reset release, then saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm <= '0;
    end else if (!w_warm_done) begin
      r_warm <= r_warm + 1'b1;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ev_out;
    logic                   r_ovf;
    logic                   w_s;
    logic                   w_ev;
    logic                   w_em;
    logic                   w_drop;
    logic                   w_gap_zero;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_ev   = w_warm_done & (TOGGLE ? (w_s ^ r_hist) : (w_s & ~r_hist));
    assign w_em   = (r_cnt != '0) & ~hold[c] & w_gap_zero;
    // A simultaneous emit frees a slot, so only an unmatched event at MAX drops.
    assign w_drop = w_ev & ~w_em & (r_cnt == MAX);

    // Synchroniser chain plus history flop used by the edge/toggle detector.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours (the chain shifts by one).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= '0;
        r_hist <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], ev_in[c]};
        r_hist <= w_s;
      end
    end

    // Pending counter, registered emit pulse and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt    <= '0;
        r_ev_out <= 1'b0;
        r_ovf    <= 1'b0;
      end else begin
        r_ev_out <= w_em;
        case ({w_ev, w_em})
          2'b10:   if (r_cnt != MAX) r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
        if (w_drop) begin
          r_ovf <= 1'b1;
        end else if (ovf_clr[c]) begin
          r_ovf <= 1'b0;
        end
      end
    end

    if (GAP > 0) begin : g_gap
      localparam int GAP_W = $clog2(GAP + 1);
      logic [GAP_W-1:0] r_gap;

      assign w_gap_zero = (r_gap == '0);

      // Spacing counter: reloads on every emit, then counts down to zero.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_gap <= '0;
        end else if (w_em) begin
          r_gap <= GAP_W'(GAP);
        end else if (!w_gap_zero) begin
          r_gap <= r_gap - 1'b1;
        end
      end
    end else begin : g_no_gap
      assign w_gap_zero = 1'b1;
    end

    assign ev_out[c]              = r_ev_out;
    assign ovf[c]                 = r_ovf;
    assign full[c]                = (r_cnt == MAX);
    assign cnt[c*CNT_W +: CNT_W]  = r_cnt;
  end

endmodule

// File: tb/tb_event_sync_queue.sv
// Bench for event_sync_queue: two instances (toggle mode with GAP=1, and
// rising-edge mode with GAP=0) share one stimulus stream. A behavioural
// model tracks sampled-input history, pending counts and last-emit times
// and is compared with both instances on every falling clock edge; directed
// scenarios add explicit expectations on top.
module tb_event_sync_queue;

  localparam int CH    = 4;
  localparam int CNT_W = 3;
  localparam int S     = 2;
  localparam int NU    = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam int VW    = 3 * CH + CH * CNT_W;
  localparam logic [5:0] LAT_OUT  = 6'b001000;
  localparam logic [5:0] LAT_CNT1 = 6'b000100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [CH-1:0] ev_in   = '0;
  logic [CH-1:0] hold    = '0;
  logic [CH-1:0] ovf_clr = '0;

  logic [CH-1:0]       ev_out_a, full_a, ovf_a;
  logic [CH-1:0]       ev_out_b, full_b, ovf_b;
  logic [CH*CNT_W-1:0] cnt_a, cnt_b;

  event_sync_queue #(.CH(CH), .CNT_W(CNT_W), .SYNC_STAGES(S), .GAP(1), .TOGGLE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ev_in(ev_in), .hold(hold), .ovf_clr(ovf_clr),
    .ev_out(ev_out_a), .full(full_a), .ovf(ovf_a), .cnt(cnt_a)
  );

  event_sync_queue #(.CH(CH), .CNT_W(CNT_W), .SYNC_STAGES(S), .GAP(0), .TOGGLE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ev_in(ev_in), .hold(hold), .ovf_clr(ovf_clr),
    .ev_out(ev_out_b), .full(full_b), .ovf(ovf_b), .cnt(cnt_b)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  int            m_t;
  int            m_cnt  [NU][CH];
  int            m_last [NU][CH];
  logic          m_out  [NU][CH];
  logic          m_ovf  [NU][CH];
  logic [CH-1:0] m_hist [0:S];  // m_hist[i]: ev_in as sampled i+1 edges ago

  function automatic int gap_of(input int u);
    return (u == 0) ? 1 : 0;
  endfunction

  function automatic bit toggle_of(input int u);
    return (u == 0);
  endfunction

  task automatic model_reset();
    m_t = 0;
    for (int i = 0; i <= S; i++) m_hist[i] = '0;
    for (int u = 0; u < NU; u++) begin
      for (int c = 0; c < CH; c++) begin
        m_cnt[u][c]  = 0;
        m_last[u][c] = -1000;
        m_out[u][c]  = 1'b0;
        m_ovf[u][c]  = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    bit s_now, s_old, ev, em, drop;
    m_t++;
    for (int u = 0; u < NU; u++) begin
      for (int c = 0; c < CH; c++) begin
        // A change sampled at edge t is seen by the detector at edge t+S.
        s_now = m_hist[S-1][c];
        s_old = m_hist[S][c];
        ev    = toggle_of(u) ? (s_now ^ s_old) : (s_now & ~s_old);
        if (m_t <= S + 1) ev = 1'b0;
        em   = (m_cnt[u][c] != 0) && !hold[c] && (m_t - m_last[u][c] > gap_of(u));
        drop = ev && !em && (m_cnt[u][c] == MAXC);
        if (ev && !em && !drop) m_cnt[u][c]++;
        else if (!ev && em)     m_cnt[u][c]--;
        if (drop)            m_ovf[u][c] = 1'b1;
        else if (ovf_clr[c]) m_ovf[u][c] = 1'b0;
        if (em) m_last[u][c] = m_t;
        m_out[u][c] = em;
      end
    end
    for (int i = S; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = ev_in;
  endtask

  function automatic logic [VW-1:0] model_vec(input int u);
    logic [CH-1:0]       o, f, v;
    logic [CH*CNT_W-1:0] k;
    o = '0; f = '0; v = '0; k = '0;
    for (int c = 0; c < CH; c++) begin
      o[c] = m_out[u][c];
      f[c] = (m_cnt[u][c] == MAXC);
      v[c] = m_ovf[u][c];
      k[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[u][c]);
    end
    return {o, f, v, k};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_edge();
  end

  // Every cycle, both instances against the model.
  always @(negedge clk) begin
    check("model_a", 32'({ev_out_a, full_a, ovf_a, cnt_a}), 32'(model_vec(0)));
    check("model_b", 32'({ev_out_b, full_b, ovf_b, cnt_b}), 32'(model_vec(1)));
  end

  // -------------------------------------------------------------- stimulus
  int pa [CH];
  int pb [CH];

  function automatic int cnt_of(input logic [CH*CNT_W-1:0] v, input int c);
    return int'(v[c*CNT_W +: CNT_W]);
  endfunction

  task automatic clear_pulses();
    for (int c = 0; c < CH; c++) begin
      pa[c] = 0;
      pb[c] = 0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        pa[c] += int'(ev_out_a[c]);
        pb[c] += int'(ev_out_b[c]);
      end
    end
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_a"}, 32'({ev_out_a, full_a, ovf_a, cnt_a}), 32'd0);
    check({tag, "_b"}, 32'({ev_out_b, full_b, ovf_b, cnt_b}), 32'd0);
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int n, last;
    int since [CH];

    // Reset with ev_in levels present; nothing may come out of warm-up.
    ev_in = 4'b0101;
    tick(3);
    check("rst_outs_a", 32'({ev_out_a, full_a, ovf_a, cnt_a}), 32'd0);
    rst_n = 1'b1;
    clear_pulses();
    tick(20);
    check("warm_pulses_a", pa[0] + pa[1] + pa[2] + pa[3], 0);
    check("warm_pulses_b", pb[0] + pb[1] + pb[2] + pb[3], 0);
    check("warm_cnt_a", 32'(cnt_a), 32'd0);
    check("warm_ovf_a", 32'(ovf_a), 32'd0);

    // Single toggle on channel 0: pulse after the 4th edge, count 0->1->0.
    clear_pulses();
    ev_in[0] = ~ev_in[0];
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check($sformatf("lat_out_%0d", i), 32'(ev_out_a[0]), 32'(LAT_OUT[i]));
      check($sformatf("lat_cnt_%0d", i), cnt_of(cnt_a, 0), 32'(LAT_CNT1[i]));
    end
    check("lat_one_pulse", pa[0], 1);
    check("lat_idle_others", pa[1] + pa[2] + pa[3], 0);
    ev_in[0] = ~ev_in[0];
    tick(8);

    // Overflow under hold on channel 1, then a spaced drain.
    hold[1] = 1'b1;
    repeat (9) begin
      ev_in[1] = ~ev_in[1];
      tick(4);
    end
    check("hold_cnt", cnt_of(cnt_a, 1), MAXC);
    check("hold_full", 32'(full_a[1]), 32'd1);
    check("hold_ovf", 32'(ovf_a[1]), 32'd1);
    hold[1] = 1'b0;
    n = 0;
    last = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ev_out_a[1]) begin
        n++;
        if (n == 1) check("full_drop", 32'(full_a[1]), 32'd0);
        else        check("drain_spacing", i - last, 2);
        last = i;
      end
    end
    check("drain_pulses", n, MAXC);
    check("drain_cnt", cnt_of(cnt_a, 1), 0);
    ovf_clr[1] = 1'b1;
    tick(1);
    ovf_clr[1] = 1'b0;

    // Channel 2 at MAX: event and first emit on the same edge.
    hold[2] = 1'b1;
    repeat (7) begin
      ev_in[2] = ~ev_in[2];
      tick(4);
    end
    check("max_cnt", cnt_of(cnt_a, 2), MAXC);
    ev_in[2] = ~ev_in[2];
    tick(2);
    hold[2] = 1'b0;
    tick(1);
    check("same_edge_emit", 32'(ev_out_a[2]), 32'd1);
    check("same_edge_cnt", cnt_of(cnt_a, 2), MAXC);
    check("same_edge_ovf", 32'(ovf_a[2]), 32'd0);
    tick(20);
    check("ch2_drained", cnt_of(cnt_a, 2), 0);

    // Channel 3: set beats clear on the same edge; a lone clear works.
    hold[3] = 1'b1;
    repeat (8) begin
      ev_in[3] = ~ev_in[3];
      tick(4);
    end
    check("ch3_ovf_set", 32'(ovf_a[3]), 32'd1);
    ev_in[3] = ~ev_in[3];
    tick(2);
    ovf_clr[3] = 1'b1;
    tick(1);
    ovf_clr[3] = 1'b0;
    check("clr_vs_drop", 32'(ovf_a[3]), 32'd1);
    tick(3);
    ovf_clr[3] = 1'b1;
    tick(1);
    ovf_clr[3] = 1'b0;
    check("lone_clr", 32'(ovf_a[3]), 32'd0);
    hold[3] = 1'b0;
    tick(20);

    // Rising-edge instance: a long high level is one event.
    ev_in[0] = 1'b0;
    tick(8);
    clear_pulses();
    ev_in[0] = 1'b1;
    tick(6);
    ev_in[0] = 1'b0;
    tick(6);
    ev_in[0] = 1'b1;
    tick(10);
    check("edge_events", pb[0], 2);

    // Build cnt=3 on the edge instance, then reset asynchronously.
    hold[0] = 1'b1;
    ev_in[0] = 1'b0;
    tick(4);
    repeat (3) begin
      ev_in[0] = 1'b1;
      tick(4);
      ev_in[0] = 1'b0;
      tick(4);
    end
    check("pre_rst_cnt_b", cnt_of(cnt_b, 0), 3);
    hold = '0;
    async_reset("async_rst");
    clear_pulses();
    tick(20);
    check("post_rst_pulses_a", pa[0] + pa[1] + pa[2] + pa[3], 0);
    check("post_rst_pulses_b", pb[0] + pb[1] + pb[2] + pb[3], 0);
    check("post_rst_cnt_b", 32'(cnt_b), 32'd0);

    // Randomized traffic respecting the minimum event spacing.
    for (int c = 0; c < CH; c++) since[c] = 10;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc == 1000) async_reset("rand_rst");
      for (int c = 0; c < CH; c++) begin
        since[c]++;
        if (since[c] >= S + 1 && $urandom_range(0, 4) == 0) begin
          ev_in[c] = ~ev_in[c];
          since[c] = 0;
        end
        if ($urandom_range(0, 15) == 0) hold[c] = ~hold[c];
        ovf_clr[c] = ($urandom_range(0, 24) == 0);
      end
      tick(1);
    end
    ovf_clr = '0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/event_sync_queue.md
# event_sync_queue

Multi-channel event synchroniser and pending-event queue in a single destination clock domain. It generalises the 3-bit write/transfer pointer pair: each channel takes an event signal from a foreign domain through a SYNC_STAGES flop chain and detects events as toggles or rising edges. It counts pending events up to a parametrised depth and replays them as single-cycle pulses with a programmable minimum spacing and per-channel hold. Used at every gsm_switch boundary where control events must cross into the switching-core clock.

## Interface
- CH, 4, number of independent channels
- CNT_W, 3, pending-counter width; MAX = 2^CNT_W-1 events stored per channel
- SYNC_STAGES, 2, synchroniser depth (>=2)
- GAP, 1, minimum idle cycles between two ev_out pulses of one channel (0 = back-to-back)
- TOGGLE, 1, 1: every transition of ev_in is one event; 0: every rising edge of ev_in is one event
- clk  input  1  single clock; all flops on posedge
- rst_n  input  1  asynchronous, active-low reset
- ev_in  input  CH  per-channel event signal, asynchronous to clk
- hold  input  CH  per-channel emission inhibit, synchronous to clk
- ovf_clr  input  CH  per-channel sticky-overflow clear pulse
- ev_out  output  CH  registered single-cycle event pulses
- full  output  CH  cnt == MAX
- ovf  output  CH  sticky: at least one event dropped
- cnt  output  CH*CNT_W  pending count, channel c at [c*CNT_W +: CNT_W]

## Operation
- rst_n low: every flop is cleared immediately, regardless of clk. This covers sync chain, history flop, cnt, gap counter, ev_out, ovf and warm-up counter. All outputs read 0.
- Sync: ev_in[c] passes through SYNC_STAGES flops to s[c]. A history flop captures s_d[c] <= s[c].
- Detect: ev[c] = TOGGLE ? (s != s_d) : (s & ~s_d). The detect is combinational from registers.
- Warm-up: a shared counter runs for SYNC_STAGES+1 cycles after rst_n rises. Detected events are discarded during that window: no count, no ovf. This prevents spurious events from ev_in levels present at reset.
- Emit condition: em[c] = (cnt != 0) & ~hold[c] & (gap == 0). It is registered as ev_out[c] <= em[c].
- Counter update per edge:
  - event & ~em: cnt+1 if cnt < MAX. If cnt == MAX, the event is dropped and ovf is set.
  - ~event & em: cnt-1.
  - event & em: cnt unchanged. This applies even at MAX, with no drop and no ovf.
  - otherwise: hold.
  - cnt never wraps.
- Gap counter: width clog2(GAP+1), omitted when GAP=0. It loads GAP on an emit and decrements to 0 otherwise.
- hold only blocks emission; events keep accumulating. Deasserting hold allows an emit on the next edge if cnt != 0 and gap == 0.
- ovf: set on a dropped event, cleared by ovf_clr. Set has priority when both occur in the same cycle.
- full = (cnt == MAX), combinational from cnt.
- Channels are fully independent; only warm-up is shared.

## Timing
- Reset values: ev_out=0, full=0, ovf=0, cnt=0.
- Latency, for an empty channel with hold=0 and gap=0:
  - Edge k first samples the ev_in change.
  - cnt increments at edge k+SYNC_STAGES.
  - ev_out is high in the cycle following edge k+SYNC_STAGES+1.
  - cnt returns to 0 at that same edge.
  - With defaults, ev_out is high after edge 4 counting edge k as 1.
- Spacing: an emit at edge e allows the next emit no earlier than edge e+GAP+1. With GAP=0, ev_out stays high for N consecutive cycles to deliver N events.
- Input requirement: ev_in events must be at least SYNC_STAGES+1 clk cycles apart, and EDGE-mode high/low phases at least 2 clk cycles. Closer events may merge; this is not flagged.
- Throughput limit: 1/(GAP+1) events per cycle per channel. Any excess accumulates up to MAX.
- Reset mid-operation: pending events are lost, outputs drop at once, and warm-up reruns after release.

## Test plan
- Defaults, ev_in=4'b0101 held through reset and release → no ev_out for 20 cycles; cnt=0 and ovf=0 on all channels.
- After warm-up, single toggle on ev_in[0] → ev_out[0] high for exactly one cycle, 4 edges after first sample; cnt[0] goes 0→1→0; other channels stay idle.
- hold[1]=1, 9 toggles on ev_in[1] spaced 4 cycles → cnt[1]=7, full[1]=1, ovf[1]=1. Release hold → exactly 7 pulses spaced 2 cycles; full[1] drops after the first pulse; cnt[1] ends at 0.
- cnt[2]=7, hold released, event detected on the same edge as the first emit → cnt stays 7, ovf[2] stays 0.
- ovf[3]=1, ovf_clr[3] pulsed on the same edge as a new dropped event → ovf[3] stays 1. A later lone ovf_clr → ovf[3]=0.
- TOGGLE=0, GAP=0: ev_in[0] high for 6 cycles, then low, then high again → exactly 2 events. Assert rst_n low with cnt=3 → all outputs 0 asynchronously, and no pulses after release.
